// File: rtl/host_mem_bridge_pkg.sv
// Shared definitions for the host-to-SRAM bridge: FSM encoding, bus-buffer polarities, defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package host_mem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DECODE     = 3'd1,
    ST_RD_WAIT    = 3'd2,
    ST_RD_DRIVE   = 3'd3,
    ST_WR_COLLECT = 3'd4,
    ST_WR_PULSE   = 3'd5,
    ST_REG_ACC    = 3'd6,
    ST_HOLD       = 3'd7
  } state_t;

  // LVC245A: DIR low drives the host side, OE is active-low.
  localparam logic DIR_TO_HOST   = 1'b0;
  localparam logic DIR_FROM_HOST = 1'b1;
  localparam logic BUF_ON        = 1'b0;
  localparam logic BUF_OFF       = 1'b1;

  localparam logic [7:0]  DEF_MAP_MASK    = 8'hE4;
  localparam logic [15:0] DEF_MAPPER_BASE = 16'h4000;

  // Byte-lane enable for a host byte address: odd address is the low byte.
  function automatic logic [1:0] lane_be(input logic odd);
    return odd ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/host_mem_bridge_page_mapper.sv
// Mapper register file: 2^PAGE_BITS 8-bit page registers, [7] = read-only, [BANK_W-1:0] = bank.
// Latency: combinational read, write takes effect on the next clock.
// Backpressure: none; a write strobe is always accepted.
// Ports: clk/reset, i_wr_en/i_wr_idx/i_wr_dat write port, i_rd_idx -> o_rd_dat/o_bank/o_ro read port.
module page_mapper #(
  parameter int PAGE_BITS = 4,
  parameter int BANK_W    = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic [PAGE_BITS-1:0] i_wr_idx,
  input  logic [7:0]           i_wr_dat,
  input  logic [PAGE_BITS-1:0] i_rd_idx,
  output logic [7:0]           o_rd_dat,
  output logic [BANK_W-1:0]    o_bank,
  output logic                 o_ro
);

  localparam int NREG = 2 ** PAGE_BITS;

  logic [7:0] r_regs [NREG];

  // Reset to the identity map so the host sees flat memory until it reprograms pages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NREG; n++) r_regs[n] <= 8'(n);
    end else if (i_wr_en) begin
      r_regs[i_wr_idx] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_regs[i_rd_idx];
  assign o_bank   = o_rd_dat[BANK_W-1:0];
  assign o_ro     = o_rd_dat[7];

endmodule

// File: rtl/host_mem_bridge.sv
// Bridges an 8-bit host memory bus to a 16-bit SRAM through a paged mapper, with a mapper register window.
// Latency: address strobe -> DECODE 1 clk, SRAM read RD_WAIT clks, write pulse WR_WAIT clks after i_we rises.
// Backpressure: none; the host bus is level-timed, i_memen high aborts any cycle except a started write pulse.
// Ports: clk/reset; host side i_addr_valid/i_addr/i_memen/i_dbin/i_we/i_map_en/i_data_bus/o_data_bus,
//        buffer o_dbdir/o_rdbena; SRAM side o_sram_address/i_sram_data/o_sram_data/o_sram_data_out_en/
//        o_sram_be/RAMCS/RAMOE/RAMWE; o_state for debug.
module host_mem_bridge
  import host_mem_bridge_pkg::*;
#(
  parameter int          PAGE_BITS   = 4,
  parameter int          BANK_W      = 7,
  parameter int          RD_WAIT     = 1,
  parameter int          WR_WAIT     = 1,
  parameter logic [7:0]  MAP_MASK    = DEF_MAP_MASK,
  parameter logic [15:0] MAPPER_BASE = DEF_MAPPER_BASE,
  localparam int         SRAM_AW     = BANK_W + 15 - PAGE_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_addr_valid,
  input  logic [15:0]        i_addr,
  input  logic               i_memen,
  input  logic               i_dbin,
  input  logic               i_we,
  input  logic               i_map_en,
  input  logic [7:0]         i_data_bus,
  output logic [7:0]         o_data_bus,
  output logic               o_dbdir,
  output logic               o_rdbena,
  output logic [SRAM_AW-1:0] o_sram_address,
  input  logic [15:0]        i_sram_data,
  output logic [15:0]        o_sram_data,
  output logic               o_sram_data_out_en,
  output logic [1:0]         o_sram_be,
  output logic               RAMCS,
  output logic               RAMOE,
  output logic               RAMWE,
  output logic [2:0]         o_state
);

  state_t               r_state;
  logic [15:0]          r_addr;
  logic [7:0]           r_cnt;
  logic                 r_we_prev;
  logic                 r_is_read;
  logic                 r_ro;
  logic [7:0]           r_wbyte;
  logic [7:0]           r_data_bus;
  logic                 r_dbdir;
  logic                 r_rdbena;
  logic                 r_ramcs;
  logic                 r_ramoe;
  logic                 r_ramwe;
  logic                 r_sram_out_en;
  logic [1:0]           r_sram_be;
  logic [SRAM_AW-1:0]   r_sram_address;
  logic [15:0]          r_sram_data;

  logic [16:0]          w_off;
  logic                 w_map_hit;
  logic                 w_sram_hit;
  logic [PAGE_BITS-1:0] w_map_idx;
  logic [7:0]           w_map_rd_dat;
  logic [BANK_W-1:0]    w_bank;
  logic                 w_map_ro;
  logic                 w_map_we;
  logic                 w_we_rise;
  logic [SRAM_AW-1:0]   w_addr_map;
  logic [SRAM_AW-1:0]   w_addr_flat;

  // 17-bit subtraction: addresses below the window wrap to a large value and miss.
  assign w_off       = {1'b0, r_addr} - {1'b0, MAPPER_BASE};
  assign w_map_hit   = i_map_en && (w_off < 17'(2 ** PAGE_BITS));
  assign w_sram_hit  = MAP_MASK[r_addr[15:13]];
  // One read port serves both the register window and the page lookup.
  assign w_map_idx   = w_map_hit ? w_off[PAGE_BITS-1:0] : r_addr[15 -: PAGE_BITS];
  assign w_addr_map  = {w_bank, r_addr[15-PAGE_BITS:1]};
  assign w_addr_flat = SRAM_AW'(r_addr[15:1]);
  assign w_we_rise   = i_we && !r_we_prev;
  assign w_map_we    = (r_state == ST_REG_ACC) && !r_is_read && !i_memen && w_we_rise;

  page_mapper #(
    .PAGE_BITS (PAGE_BITS),
    .BANK_W    (BANK_W)
  ) u_page_mapper (
    .clk      (clk),
    .reset    (reset),
    .i_wr_en  (w_map_we),
    .i_wr_idx (w_off[PAGE_BITS-1:0]),
    .i_wr_dat (r_wbyte),
    .i_rd_idx (w_map_idx),
    .o_rd_dat (w_map_rd_dat),
    .o_bank   (w_bank),
    .o_ro     (w_map_ro)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_cnt          <= '0;
      r_we_prev      <= 1'b1;
      r_is_read      <= 1'b0;
      r_ro           <= 1'b0;
      r_wbyte        <= '0;
      r_data_bus     <= '0;
      r_dbdir        <= DIR_FROM_HOST;
      r_rdbena       <= BUF_OFF;
      r_ramcs        <= 1'b1;
      r_ramoe        <= 1'b1;
      r_ramwe        <= 1'b1;
      r_sram_out_en  <= 1'b0;
      r_sram_be      <= 2'b00;
      r_sram_address <= '0;
      r_sram_data    <= '0;
    end else begin
      r_we_prev <= i_we;
      case (r_state)
        ST_IDLE: begin
          if (i_addr_valid && !i_memen) begin
            r_addr  <= i_addr;
            r_state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (i_memen) begin
            r_state <= ST_IDLE;
          end else if (w_map_hit) begin
            r_state    <= ST_REG_ACC;
            r_is_read  <= i_dbin;
            r_rdbena   <= BUF_ON;
            r_dbdir    <= i_dbin ? DIR_TO_HOST : DIR_FROM_HOST;
            r_data_bus <= i_dbin ? w_map_rd_dat : 8'h00;
          end else if (w_sram_hit) begin
            r_sram_address <= i_map_en ? w_addr_map : w_addr_flat;
            r_ro           <= i_map_en && w_map_ro;
            if (i_dbin) begin
              r_state <= ST_RD_WAIT;
              r_ramcs <= 1'b0;
              r_ramoe <= 1'b0;
              r_cnt   <= 8'(RD_WAIT - 1);
            end else begin
              r_state  <= ST_WR_COLLECT;
              r_rdbena <= BUF_ON;
              r_dbdir  <= DIR_FROM_HOST;
            end
          end else begin
            r_state <= ST_HOLD;
          end
        end

        ST_RD_WAIT: begin
          if (i_memen) begin
            r_state <= ST_IDLE;
            r_ramcs <= 1'b1;
            r_ramoe <= 1'b1;
          end else if (r_cnt == 8'd0) begin
            r_state    <= ST_RD_DRIVE;
            r_ramcs    <= 1'b1;
            r_ramoe    <= 1'b1;
            r_data_bus <= r_addr[0] ? i_sram_data[7:0] : i_sram_data[15:8];
            r_dbdir    <= DIR_TO_HOST;
            r_rdbena   <= BUF_ON;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        ST_RD_DRIVE: begin
          if (i_memen || !i_dbin) begin
            r_state    <= ST_IDLE;
            r_dbdir    <= DIR_FROM_HOST;
            r_rdbena   <= BUF_OFF;
            r_data_bus <= 8'h00;
          end
        end

        ST_WR_COLLECT: begin
          if (i_memen) begin
            r_state  <= ST_IDLE;
            r_rdbena <= BUF_OFF;
          end else if (!i_we) begin
            r_wbyte <= i_data_bus;
          end else if (w_we_rise) begin
            // Committed from here: the pulse runs its full length even if the host aborts.
            r_state       <= ST_WR_PULSE;
            r_rdbena      <= BUF_OFF;
            r_ramcs       <= 1'b0;
            r_ramwe       <= r_ro;
            r_sram_out_en <= 1'b1;
            r_sram_be     <= lane_be(r_addr[0]);
            r_sram_data   <= {r_wbyte, r_wbyte};
            r_cnt         <= 8'(WR_WAIT - 1);
          end
        end

        ST_WR_PULSE: begin
          if (r_cnt == 8'd0) begin
            r_state       <= ST_HOLD;
            r_ramcs       <= 1'b1;
            r_ramwe       <= 1'b1;
            r_sram_out_en <= 1'b0;
            r_sram_be     <= 2'b00;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        ST_REG_ACC: begin
          if (i_memen || (r_is_read && !i_dbin)) begin
            r_state    <= ST_IDLE;
            r_dbdir    <= DIR_FROM_HOST;
            r_rdbena   <= BUF_OFF;
            r_data_bus <= 8'h00;
          end else if (!r_is_read) begin
            if (!i_we) begin
              r_wbyte <= i_data_bus;
            end else if (w_we_rise) begin
              r_state  <= ST_HOLD;
              r_rdbena <= BUF_OFF;
            end
          end
        end

        ST_HOLD: begin
          if (i_memen) r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The host never sees stale data while the buffer points toward the bridge.
  assign o_data_bus         = (r_dbdir == DIR_FROM_HOST) ? 8'h00 : r_data_bus;
  assign o_dbdir            = r_dbdir;
  assign o_rdbena           = r_rdbena;
  assign o_sram_address     = r_sram_address;
  assign o_sram_data        = r_sram_data;
  assign o_sram_data_out_en = r_sram_out_en;
  assign o_sram_be          = r_sram_be;
  assign RAMCS              = r_ramcs;
  assign RAMOE              = r_ramoe;
  assign RAMWE              = r_ramwe;
  assign o_state            = r_state;

endmodule

// File: tb/tb_host_mem_bridge.sv
module tb_host_mem_bridge;

  localparam int TB_RD_WAIT = 2;
  localparam int TB_WR_WAIT = 3;
  localparam int AW         = 18;
  localparam logic [2:0] S_IDLE = 3'd0, S_RD_WAIT = 3'd2, S_WR_COLLECT = 3'd4,
                         S_WR_PULSE = 3'd5, S_HOLD = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_addr_valid;
  logic [15:0]   i_addr;
  logic          i_memen, i_dbin, i_we, i_map_en;
  logic [7:0]    i_data_bus, o_data_bus;
  logic          o_dbdir, o_rdbena;
  logic [AW-1:0] o_sram_address;
  logic [15:0]   i_sram_data, o_sram_data;
  logic          o_sram_data_out_en;
  logic [1:0]    o_sram_be;
  logic          RAMCS, RAMOE, RAMWE;
  logic [2:0]    o_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cs_cnt, oe_cnt, we_cnt, buf_cnt;
  logic [1:0] be_seen;
  logic [15:0] sram [0:(1<<AW)-1];

  // Region 1 (2000h) is enabled on top of the default mask so low-memory vectors hit SRAM.
  host_mem_bridge #(
    .PAGE_BITS(4), .BANK_W(7), .RD_WAIT(TB_RD_WAIT), .WR_WAIT(TB_WR_WAIT),
    .MAP_MASK(8'hE6), .MAPPER_BASE(16'h4000)
  ) dut (
    .clk(clk), .reset(reset), .i_addr_valid(i_addr_valid), .i_addr(i_addr),
    .i_memen(i_memen), .i_dbin(i_dbin), .i_we(i_we), .i_map_en(i_map_en),
    .i_data_bus(i_data_bus), .o_data_bus(o_data_bus), .o_dbdir(o_dbdir), .o_rdbena(o_rdbena),
    .o_sram_address(o_sram_address), .i_sram_data(i_sram_data), .o_sram_data(o_sram_data),
    .o_sram_data_out_en(o_sram_data_out_en), .o_sram_be(o_sram_be),
    .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMWE(RAMWE), .o_state(o_state)
  );

  always #5 clk = ~clk;

  assign i_sram_data = RAMOE ? 16'h0000 : sram[o_sram_address];

  // SRAM model and strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!RAMCS) cs_cnt++;
    if (!RAMCS && !RAMOE) oe_cnt++;
    if (!RAMCS && !RAMWE) begin
      we_cnt++;
      if (o_sram_data_out_en && o_sram_be[1]) sram[o_sram_address][15:8] = o_sram_data[15:8];
      if (o_sram_data_out_en && o_sram_be[0]) sram[o_sram_address][7:0]  = o_sram_data[7:0];
    end
    if (!RAMCS && o_sram_data_out_en) be_seen = o_sram_be;
    if (!o_rdbena) buf_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic clear_mon();
    cs_cnt = 0; oe_cnt = 0; we_cnt = 0; buf_cnt = 0; be_seen = 2'b00;
  endtask

  task automatic start_cycle(input logic [15:0] a, input logic dbin);
    @(negedge clk);
    clear_mon();
    i_addr = a; i_dbin = dbin; i_we = 1'b1; i_memen = 1'b0; i_addr_valid = 1'b1;
    @(negedge clk);
    i_addr_valid = 1'b0;
  endtask

  task automatic end_cycle();
    i_memen = 1'b1; i_dbin = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (o_state == s) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic bus_read(input logic [15:0] a, output bit ok);
    start_cycle(a, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (o_dbdir == 1'b0 && o_rdbena == 1'b0) ok = 1'b1;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, output bit ok);
    start_cycle(a, 1'b0);
    i_data_bus = d; i_we = 1'b0;
    repeat (2) @(negedge clk);
    i_we = 1'b1;
    wait_state(S_HOLD, ok);
    end_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0; i_addr_valid = 1'b0; i_addr = '0; i_memen = 1'b1; i_dbin = 1'b0;
    i_we = 1'b1; i_map_en = 1'b0; i_data_bus = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_state !== S_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want 0", o_state); end
    n_cmp++; if ({RAMCS, RAMOE, RAMWE} !== 3'b111) begin n_bad++; $display("FAIL rst_strobes: got %b want 111", {RAMCS, RAMOE, RAMWE}); end
    n_cmp++; if ({o_dbdir, o_rdbena} !== 2'b11) begin n_bad++; $display("FAIL rst_buffer: got %b want 11", {o_dbdir, o_rdbena}); end
    n_cmp++; if (o_sram_data_out_en !== 1'b0 || o_sram_be !== 2'b00) begin n_bad++; $display("FAIL rst_sram_drive: got %b/%b want 0/00", o_sram_data_out_en, o_sram_be); end
    n_cmp++; if (o_sram_address !== '0 || o_sram_data !== 16'h0) begin n_bad++; $display("FAIL rst_sram_bus: got %h/%h want 0/0", o_sram_address, o_sram_data); end
    n_cmp++; if (o_data_bus !== 8'h00) begin n_bad++; $display("FAIL rst_data_bus: got %h want 00", o_data_bus); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_map_off();
    bit ok;
    sram[18'h05001] = 16'h1234;
    i_map_en = 1'b0;
    bus_read(16'hA002, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rd_a002_timeout: got 0 want 1"); end
    n_cmp++; if (o_data_bus !== 8'h12) begin n_bad++; $display("FAIL rd_a002_data: got %h want 12", o_data_bus); end
    n_cmp++; if (o_sram_address !== 18'h05001) begin n_bad++; $display("FAIL rd_a002_addr: got %h want 05001", o_sram_address); end
    n_cmp++; if (oe_cnt != TB_RD_WAIT) begin n_bad++; $display("FAIL rd_a002_oe_clocks: got %0d want %0d", oe_cnt, TB_RD_WAIT); end
    end_cycle();
    n_cmp++; if (o_state !== S_IDLE || o_rdbena !== 1'b1 || o_dbdir !== 1'b1) begin n_bad++; $display("FAIL rd_a002_release: got st=%0d ena=%b dir=%b want 0/1/1", o_state, o_rdbena, o_dbdir); end
    n_cmp++; if (o_data_bus !== 8'h00) begin n_bad++; $display("FAIL rd_a002_bus_zero: got %h want 00", o_data_bus); end
    bus_read(16'hA003, ok);
    n_cmp++; if (!ok || o_data_bus !== 8'h34) begin n_bad++; $display("FAIL rd_a003_low_byte: got %h want 34", o_data_bus); end
    end_cycle();
  endtask

  task automatic test_write_lane();
    bit ok;
    sram[18'h01000] = 16'hABCD;
    bus_write(16'h2001, 8'h55, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_2001_timeout: got 0 want 1"); end
    n_cmp++; if (be_seen !== 2'b01) begin n_bad++; $display("FAIL wr_2001_be: got %b want 01", be_seen); end
    n_cmp++; if (sram[18'h01000] !== 16'hAB55) begin n_bad++; $display("FAIL wr_2001_word: got %h want AB55", sram[18'h01000]); end
    n_cmp++; if (we_cnt != TB_WR_WAIT || cs_cnt != TB_WR_WAIT) begin n_bad++; $display("FAIL wr_2001_pulse: got we=%0d cs=%0d want %0d", we_cnt, cs_cnt, TB_WR_WAIT); end
    bus_write(16'h2000, 8'h66, ok);
    n_cmp++; if (be_seen !== 2'b10) begin n_bad++; $display("FAIL wr_2000_be: got %b want 10", be_seen); end
    n_cmp++; if (sram[18'h01000] !== 16'h6655) begin n_bad++; $display("FAIL wr_2000_word: got %h want 6655", sram[18'h01000]); end
  endtask

  task automatic test_mapper();
    bit ok;
    i_map_en = 1'b1;
    sram[18'h02800] = 16'hBEEF;
    bus_write(16'h400E, 8'h05, ok);
    bus_write(16'h4002, 8'h05, ok);
    n_cmp++; if (cs_cnt != 0) begin n_bad++; $display("FAIL map_reg_wr_no_sram: got cs=%0d want 0", cs_cnt); end
    bus_read(16'h4002, ok);
    n_cmp++; if (!ok || o_data_bus !== 8'h05) begin n_bad++; $display("FAIL map_reg_rd: got %h want 05", o_data_bus); end
    end_cycle();
    bus_read(16'hE000, ok);
    n_cmp++; if (o_sram_address !== {7'h05, 11'h000}) begin n_bad++; $display("FAIL map_e000_addr: got %h want 02800", o_sram_address); end
    n_cmp++; if (!ok || o_data_bus !== 8'hBE) begin n_bad++; $display("FAIL map_e000_data: got %h want BE", o_data_bus); end
    end_cycle();
    bus_read(16'h2001, ok);
    n_cmp++; if (!ok || o_sram_address !== 18'h02800 || o_data_bus !== 8'hEF) begin n_bad++; $display("FAIL map_2001: got %h/%h want 02800/EF", o_sram_address, o_data_bus); end
    end_cycle();
  endtask

  task automatic test_read_only();
    bit ok;
    i_map_en = 1'b1;
    bus_write(16'h4002, 8'h85, ok);
    bus_write(16'h2000, 8'h77, ok);
    n_cmp++; if (!ok || cs_cnt != TB_WR_WAIT) begin n_bad++; $display("FAIL ro_timing: got cs=%0d want %0d", cs_cnt, TB_WR_WAIT); end
    n_cmp++; if (we_cnt != 0) begin n_bad++; $display("FAIL ro_we_low: got %0d want 0", we_cnt); end
    n_cmp++; if (sram[18'h02800] !== 16'hBEEF) begin n_bad++; $display("FAIL ro_word: got %h want BEEF", sram[18'h02800]); end
    i_map_en = 1'b0;
  endtask

  task automatic test_unmapped();
    bit ok;
    start_cycle(16'h6000, 1'b1);
    wait_state(S_HOLD, ok);
    repeat (3) @(negedge clk);
    n_cmp++; if (!ok || o_state !== S_HOLD) begin n_bad++; $display("FAIL um_hold: got %0d want 7", o_state); end
    n_cmp++; if (buf_cnt != 0 || o_rdbena !== 1'b1 || cs_cnt != 0) begin n_bad++; $display("FAIL um_buffer: got ena_low=%0d cs=%0d want 0/0", buf_cnt, cs_cnt); end
    end_cycle();
    n_cmp++; if (o_state !== S_IDLE) begin n_bad++; $display("FAIL um_idle: got %0d want 0", o_state); end
  endtask

  task automatic test_abort();
    start_cycle(16'hA002, 1'b1);
    @(negedge clk);
    n_cmp++; if (o_state !== S_RD_WAIT || RAMOE !== 1'b0) begin n_bad++; $display("FAIL ab_rd_in_wait: got st=%0d oe=%b want 2/0", o_state, RAMOE); end
    i_memen = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_state !== S_IDLE || RAMCS !== 1'b1 || RAMOE !== 1'b1) begin n_bad++; $display("FAIL ab_rd: got st=%0d cs=%b oe=%b want 0/1/1", o_state, RAMCS, RAMOE); end
    sram[18'h01000] = 16'h1111;
    start_cycle(16'h2001, 1'b0);
    i_data_bus = 8'h99; i_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_state !== S_WR_COLLECT) begin n_bad++; $display("FAIL ab_wr_collect: got %0d want 4", o_state); end
    i_memen = 1'b1;
    @(negedge clk);
    i_we = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_state !== S_IDLE || we_cnt != 0 || sram[18'h01000] !== 16'h1111) begin n_bad++; $display("FAIL ab_wr: got st=%0d we=%0d word=%h want 0/0/1111", o_state, we_cnt, sram[18'h01000]); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    start_cycle(16'h2001, 1'b0);
    i_data_bus = 8'h11; i_we = 1'b0;
    repeat (2) @(negedge clk);
    i_we = 1'b1;
    wait_state(S_WR_PULSE, ok);
    n_cmp++; if (!ok || RAMWE !== 1'b0) begin n_bad++; $display("FAIL rmw_in_pulse: got we=%b want 0", RAMWE); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({RAMCS, RAMOE, RAMWE} !== 3'b111 || o_state !== S_IDLE) begin n_bad++; $display("FAIL rmw_release: got %b st=%0d want 111/0", {RAMCS, RAMOE, RAMWE}, o_state); end
    n_cmp++; if (o_sram_data_out_en !== 1'b0 || o_rdbena !== 1'b1) begin n_bad++; $display("FAIL rmw_drive: got en=%b ena=%b want 0/1", o_sram_data_out_en, o_rdbena); end
    i_memen = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    i_map_en = 1'b1;
    bus_read(16'h4002, ok);
    n_cmp++; if (!ok || o_data_bus !== 8'h02) begin n_bad++; $display("FAIL rmw_identity_r2: got %h want 02", o_data_bus); end
    end_cycle();
    bus_read(16'h4005, ok);
    n_cmp++; if (!ok || o_data_bus !== 8'h05) begin n_bad++; $display("FAIL rmw_identity_r5: got %h want 05", o_data_bus); end
    end_cycle();
    i_map_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_map_off();
    test_write_lane();
    test_mapper();
    test_read_only();
    test_unmapped();
    test_abort();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
